// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: 2-entry skid buffer between the ALU and the
// memory stage, with branch resolution and a forwarding tap.
// in_ready comes straight from the skid-register valid flop, so it has no
// combinational path from out_ready.
// Optional macro EX_MEM_PERF_EN: enables the backpressure stall counter on
// perf_stall_cnt; when undefined the port is tied to zero.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_branch,
  input  logic [DATA_W-1:0] in_branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_pending,
  output logic [15:0]       perf_stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  entry_t h_q, h_d, s_q, s_d, in_e;
  logic   h_valid_q, h_valid_d, s_valid_q, s_valid_d;
  logic   accept, pop, br_hit;
  logic   branch_taken_q;
  logic [DATA_W-1:0] branch_target_q;

  assign in_e = '{alu_result: in_alu_result, store_data: in_store_data,
                  rd: in_rd, reg_write: in_reg_write,
                  mem_read: in_mem_read, mem_write: in_mem_write};

  assign in_ready = !s_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = h_valid_q & out_ready;
  assign br_hit   = accept & in_branch & in_zero & !flush;

  // Next-state for head/skid entries; flush has top priority.
  always_comb begin
    h_d       = h_q;
    s_d       = s_q;
    h_valid_d = h_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!h_valid_q || pop) begin
      if (s_valid_q) begin
        h_d       = s_q;
        h_valid_d = 1'b1;
        s_valid_d = accept;
        if (accept) s_d = in_e;
      end else begin
        h_valid_d = accept;
        if (accept) h_d = in_e;
      end
    end else if (accept) begin
      s_d       = in_e;
      s_valid_d = 1'b1;
    end
  end

  // Entry storage registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_q       <= '0;
      s_q       <= '0;
      h_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      s_q       <= s_d;
      h_valid_q <= h_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  // One-cycle branch pulse, raised on acceptance regardless of downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      branch_taken_q <= br_hit;
      if (br_hit) branch_target_q <= in_branch_target;
    end
  end

  assign out_valid      = h_valid_q;
  assign out_alu_result = h_q.alu_result;
  assign out_store_data = h_q.store_data;
  assign out_rd         = h_q.rd;
  assign out_reg_write  = h_q.reg_write;
  assign out_mem_read   = h_q.mem_read;
  assign out_mem_write  = h_q.mem_write;
  assign branch_taken   = branch_taken_q;
  assign branch_target  = branch_target_q;

  assign fwd_valid    = h_valid_q & h_q.reg_write & !h_q.mem_read & (h_q.rd != '0);
  assign fwd_rd       = h_q.rd;
  assign fwd_data     = h_q.alu_result;
  assign load_pending = h_valid_q & h_q.reg_write & h_q.mem_read & (h_q.rd != '0);

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the head is held by backpressure; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (h_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule
